// File: rtl/dsp_frame_sequencer.sv
// Multi-channel frame sequencer: feeds one frame of samples through a shared DSP core
// channel by channel, or passes the frame straight through in bypass mode.
module dsp_frame_sequencer #(
    parameter int data_width     = 16,
    parameter int n_channels     = 2,
    parameter int timeout_cycles = 4096,
    parameter int ctr_width      = 32
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    full_reset,
    input  logic                                                    enable,
    input  logic [n_channels*data_width-1:0]                        in_frame,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    output logic [n_channels*data_width-1:0]                        out_frame,
    output logic                                                    out_valid,
    output logic                                                    core_tick,
    output logic [data_width-1:0]                                   core_sample_in,
    output logic [((n_channels > 2) ? $clog2(n_channels) : 1)-1:0]  core_channel,
    input  logic [data_width-1:0]                                   core_sample_out,
    input  logic                                                    core_ready,
    output logic                                                    error,
    output logic [ctr_width-1:0]                                    overrun_ctr,
    output logic [ctr_width-1:0]                                    frame_ctr
);

    localparam int CH_W = (n_channels > 2) ? $clog2(n_channels) : 1;
    localparam int FW   = n_channels * data_width;
    localparam int WD_W = $clog2(timeout_cycles + 1);

    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(n_channels - 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(timeout_cycles);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_GUARD,
        S_WAIT,
        S_DONE,
        S_BYPASS,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [WD_W-1:0]       r_wd;
    logic [FW-1:0]         r_in_frame;
    logic [FW-1:0]         r_slots;
    logic [FW-1:0]         r_out_frame;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_core_tick;
    logic                  r_error;
    logic [data_width-1:0] r_core_sample_in;
    logic [ctr_width-1:0]  r_overrun_ctr;
    logic [ctr_width-1:0]  r_frame_ctr;

    logic                  w_rst;
    logic                  w_accept;
    logic                  w_overrun;
    logic                  w_last;
    logic                  w_timeout;
    logic [CH_W-1:0]       w_ch_next;
    logic [WD_W-1:0]       w_wd_next;
    logic [data_width-1:0] w_next_sample;
    logic [FW-1:0]         w_slots_cap;

    assign w_rst     = reset | full_reset;
    assign w_accept  = in_valid & r_in_ready;
    assign w_overrun = in_valid & ~r_in_ready;
    assign w_last    = (r_ch == LAST_CH);
    assign w_wd_next = r_wd + 1'b1;
    assign w_timeout = (w_wd_next >= WD_LIMIT);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_ch_next     = w_last ? '0 : r_ch + 1'b1;
        w_next_sample = r_in_frame[int'(w_ch_next)*data_width +: data_width];
        w_slots_cap   = r_slots;
        w_slots_cap[int'(r_ch)*data_width +: data_width] = core_sample_out;
    end

    // NOTE: frame and slot storage is pure datapath, always written before it is read,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_in_frame <= in_frame;
        end
        if (r_state == S_WAIT && core_ready) begin
            r_slots <= w_slots_cap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state          <= S_IDLE;
            r_ch             <= '0;
            r_wd             <= '0;
            r_out_frame      <= '0;
            r_in_ready       <= 1'b1;
            r_out_valid      <= 1'b0;
            r_core_tick      <= 1'b0;
            r_error          <= 1'b0;
            r_core_sample_in <= '0;
            r_overrun_ctr    <= '0;
            r_frame_ctr      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_core_tick <= 1'b0;

            // Dropped frames are counted in every state and never disturb the frame in flight.
            if (w_overrun && r_overrun_ctr != '1) begin
                r_overrun_ctr <= r_overrun_ctr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_frame_ctr <= r_frame_ctr + 1'b1;
                        r_in_ready  <= 1'b0;
                        if (enable) begin
                            r_ch             <= '0;
                            r_core_tick      <= 1'b1;
                            r_core_sample_in <= in_frame[data_width-1:0];
                            r_state          <= S_ISSUE;
                        end else begin
                            r_state <= S_BYPASS;
                        end
                    end
                end

                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT_GUARD;
                end

                // The core still shows the previous ready here; it drops a cycle after the tick.
                S_WAIT_GUARD: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (core_ready) begin
                        if (w_last) begin
                            r_out_frame <= w_slots_cap;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_ch             <= w_ch_next;
                            r_core_tick      <= 1'b1;
                            r_core_sample_in <= w_next_sample;
                            r_state          <= S_ISSUE;
                        end
                    end else begin
                        r_wd <= w_wd_next;
                        if (w_timeout) begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end
                    end
                end

                S_BYPASS: begin
                    r_out_frame <= r_in_frame;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                // Output is presented during DONE; the next frame is accepted one cycle later.
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end

                S_ERROR: begin
                    r_error    <= 1'b1;
                    r_in_ready <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign out_frame      = r_out_frame;
    assign out_valid      = r_out_valid;
    assign core_tick      = r_core_tick;
    assign core_sample_in = r_core_sample_in;
    assign core_channel   = r_ch;
    assign error          = r_error;
    assign overrun_ctr    = r_overrun_ctr;
    assign frame_ctr      = r_frame_ctr;

endmodule
